nibble_serial_adder: RTL and testbench

//  Multi-word add/subtract engine for wide operands built around one 4-bit

---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_if.sv | 29 ++
 rtl/nibble_serial_adder_cla4.sv | 30 +++
 rtl/nibble_serial_adder.sv | 104 ++++++++++
 tb/tb_nibble_serial_adder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants for the nibble-serial adder
package nsa_pkg;
  localparam int NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  import nsa_pkg::*;
  localparam int W = NIB_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  modport master (
    output in_valid, a, b, ci, op_sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, op_sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// rtl/nibble_serial_adder_cla4.sv - 4-bit carry-lookahead adder slice
module nibble_cla4
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c3
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from g/p and ci so no carry ripples through the slice.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];
  assign c3 = c[3];
endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide add/subtract engine, one nibble per cycle LSB first
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     sum_q;
  logic             co_q;
  logic             ovf_q;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] s_nib;
  logic             co_nib;
  logic             c3_nib;

  assign a_nib = a_q[NIB_W*idx +: NIB_W];
  assign b_nib = b_q[NIB_W*idx +: NIB_W];

  nibble_cla4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (s_nib),
    .co (co_nib),
    .c3 (c3_nib)
  );

  // in_ready is registered so it stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b ^ {W{bus.op_sub}};
            carry      <= bus.op_sub | bus.ci;
            idx        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          sum_q[NIB_W*idx +: NIB_W] <= s_nib;
          carry                     <= co_nib;
          if (idx == IDX_LAST) begin
            co_q        <= co_nib;
            ovf_q       <= c3_nib ^ co_nib;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder at NIBBLES=4, 1 and 8
module tb_nibble_serial_adder;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();
  nibble_serial_adder_if #(.NIBBLES(8)) bus8 ();

  nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  nibble_serial_adder #(.NIBBLES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int nib(input int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 8;
  endfunction

  function automatic logic get_in_ready(input int s);
    return (s == 0) ? bus4.in_ready : (s == 1) ? bus1.in_ready : bus8.in_ready;
  endfunction

  function automatic logic get_out_valid(input int s);
    return (s == 0) ? bus4.out_valid : (s == 1) ? bus1.out_valid : bus8.out_valid;
  endfunction

  function automatic logic [31:0] get_sum(input int s);
    return (s == 0) ? {16'd0, bus4.sum} : (s == 1) ? {28'd0, bus1.sum} : bus8.sum;
  endfunction

  function automatic logic get_co(input int s);
    return (s == 0) ? bus4.co : (s == 1) ? bus1.co : bus8.co;
  endfunction

  function automatic logic get_ovf(input int s);
    return (s == 0) ? bus4.ovf : (s == 1) ? bus1.ovf : bus8.ovf;
  endfunction

  task automatic drive_in(input int s, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sub);
    case (s)
      0: begin bus4.in_valid = v; bus4.a = a[15:0]; bus4.b = b[15:0]; bus4.ci = ci; bus4.op_sub = sub; end
      1: begin bus1.in_valid = v; bus1.a = a[3:0];  bus1.b = b[3:0];  bus1.ci = ci; bus1.op_sub = sub; end
      default: begin bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.ci = ci; bus8.op_sub = sub; end
    endcase
  endtask

  // Reference: plain integer arithmetic; overflow is the true signed result leaving the W-bit range.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic sub, output logic [31:0] sum, output logic co, output logic ovf);
    longint unsigned mask, ua, ub, full;
    longint sa, sb, r, half;
    mask = (64'd1 << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    full = sub ? (ua + ((~ub) & mask) + 1) : (ua + ub + longint'(ci));
    sum  = 32'(full & mask);
    co   = full[w];
    half = longint'(64'd1 << (w - 1));
    sa   = (ua >= half) ? longint'(ua) - 2 * half : longint'(ua);
    sb   = (ub >= half) ? longint'(ub) - 2 * half : longint'(ub);
    r    = sub ? sa - sb : sa + sb + longint'(ci);
    ovf  = (r < -half) || (r > half - 1);
  endtask

  task automatic run_op(input int s, input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sub, input logic [31:0] esum,
                        input logic eco, input logic eovf);
    int t;
    int lat;
    t = 0;
    while (!get_in_ready(s) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({nm, ".in_ready"}, 32'(get_in_ready(s)), 32'd1);
    drive_in(s, 1'b1, a, b, ci, sub);
    @(posedge clk);
    @(negedge clk);
    drive_in(s, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
    lat = 0;
    while (!get_out_valid(s) && lat < 50) begin
      check({nm, ".busy_in_ready"}, 32'(get_in_ready(s)), 32'd0);
      @(negedge clk);
      lat++;
    end
    check({nm, ".latency"}, 32'(lat), 32'(nib(s)));
    check({nm, ".sum"}, get_sum(s), esum);
    check({nm, ".co"}, 32'(get_co(s)), 32'(eco));
    check({nm, ".ovf"}, 32'(get_ovf(s)), 32'(eovf));
    check({nm, ".done_in_ready"}, 32'(get_in_ready(s)), 32'd0);
    @(negedge clk);
    check({nm, ".out_valid_cleared"}, 32'(get_out_valid(s)), 32'd0);
    check({nm, ".in_ready_back"}, 32'(get_in_ready(s)), 32'd1);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] es;
    logic        ec, eo;
    logic [31:0] held;
    int          t;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    for (int s = 0; s < 3; s++) drive_in(s, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus4.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    bus8.out_ready = 1'b1;

    vecs.push_back('{32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0});
    vecs.push_back('{32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h0007, 32'h0005, 1'b0, 1'b1, 32'h0002, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1});
    vecs.push_back('{32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{32'h00FF, 32'h0000, 1'b1, 1'b0, 32'h0100, 1'b0, 1'b0});
    vecs.push_back('{32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0});

    #12;
    check("reset.in_ready", 32'(bus4.in_ready), 32'd0);
    check("reset.out_valid", 32'(bus4.out_valid), 32'd0);
    check("reset.sum", 32'(bus4.sum), 32'd0);
    check("reset.co_ovf", {30'd0, bus4.co, bus4.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release.in_ready_low", 32'(bus4.in_ready), 32'd0);
    @(negedge clk);
    check("release.in_ready_high", 32'(bus4.in_ready), 32'd1);

    foreach (vecs[i])
      run_op(0, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub,
             vecs[i].sum, vecs[i].co, vecs[i].ovf);

    run_op(1, "n1_add", 32'h2, 32'h3, 1'b0, 1'b0, 32'h5, 1'b0, 1'b0);
    run_op(1, "n1_carry", 32'hF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op(1, "n1_ovf", 32'h7, 32'h1, 1'b0, 1'b0, 32'h8, 1'b0, 1'b1);
    run_op(2, "n8_add", 32'h12345678, 32'h43214321, 1'b0, 1'b0, 32'h55559999, 1'b0, 1'b0);
    run_op(2, "n8_carry", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: result must hold and new operands must be ignored while DONE.
    bus4.out_ready = 1'b0;
    drive_in(0, 1'b1, 32'h1111, 32'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    t = 0;
    while (!bus4.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("bp.out_valid", 32'(bus4.out_valid), 32'd1);
    held = {16'd0, bus4.sum};
    check("bp.sum", held, 32'h3333);
    for (int i = 0; i < 5; i++) begin
      drive_in(0, 1'b1, 32'hAAAA, 32'h5555, 1'b0, 1'b1);
      @(negedge clk);
      check($sformatf("bp.hold_valid%0d", i), 32'(bus4.out_valid), 32'd1);
      check($sformatf("bp.hold_sum%0d", i), {16'd0, bus4.sum}, 32'h3333);
      check($sformatf("bp.hold_in_ready%0d", i), 32'(bus4.in_ready), 32'd0);
    end
    drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("bp.release_valid", 32'(bus4.out_valid), 32'd0);
    check("bp.release_in_ready", 32'(bus4.in_ready), 32'd1);
    run_op(0, "bp.after", 32'h0001, 32'h0001, 1'b0, 1'b0, 32'h0002, 1'b0, 1'b0);

    // Reset during RUN with two nibbles already written.
    drive_in(0, 1'b1, 32'h1234, 32'h4321, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_run.out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_run.sum", 32'(bus4.sum), 32'd0);
    check("rst_run.in_ready", 32'(bus4.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rst_run.no_result%0d", i), 32'(bus4.out_valid), 32'd0);
    end
    run_op(0, "rst_run.after", 32'h0001, 32'h0001, 1'b0, 1'b0, 32'h0002, 1'b0, 1'b0);

    for (int i = 0; i < 45; i++) begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      int          s;
      s  = i % 3;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i % 9 == 4) rb = ra;
      model(4 * nib(s), ra, rb, rc, rs, es, ec, eo);
      run_op(s, $sformatf("rand%0d", i), ra, rb, rc, rs, es, ec, eo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
